// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
// State encoding, size codes, fetch-fixed fields, one-hot grant codes.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2
`ifdef RAM_TIMEOUT_EN
    ,
    S_ABORT = 2'd3
`endif
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic              FETCH_RW    = 1'b1;
  localparam logic [1:0]        FETCH_SIZE  = SIZE_WORD;
  localparam logic [DATA_W-1:0] FETCH_WDATA = '0;

  localparam logic [1:0] GNT_FETCH = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM bundle for the RAM port arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchDone;
  logic              dataReq;
  logic [ADDR_W-1:0] dataAddr;
  logic              dataRW;
  logic [1:0]        dataSize;
  logic [DATA_W-1:0] dataWData;
  logic              dataDone;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              ramMFA;
  logic              ramRW;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramDataIn;
  logic [1:0]        ramDataSize;
  logic              ramMFC;
  logic [DATA_W-1:0] ramDataOut;

  modport slave (
    input  fetchReq, fetchAddr,
    input  dataReq, dataAddr, dataRW,
    input  dataSize, dataWData,
    input  ramMFC, ramDataOut,
    output fetchDone, dataDone,
    output rdata, err,
    output ramMFA, ramRW, ramAddress,
    output ramDataIn, ramDataSize
  );

  modport master (
    output fetchReq, fetchAddr,
    output dataReq, dataAddr, dataRW,
    output dataSize, dataWData,
    output ramMFC, ramDataOut,
    input  fetchDone, dataDone,
    input  rdata, err,
    input  ramMFA, ramRW, ramAddress,
    input  ramDataIn, ramDataSize
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the side that lost last.
// In: req_fetch, req_data, last_data (1 = data won last); out: gnt one-hot.
import ram_port_arbiter_pkg::*;

module rr_arbiter2 (
  input  logic       req_fetch,
  input  logic       req_data,
  input  logic       last_data,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      req_fetch && req_data:
        gnt = last_data ? GNT_FETCH : GNT_DATA;
      req_fetch && !req_data:
        gnt = GNT_FETCH;
      !req_fetch && req_data:
        gnt = GNT_DATA;
      default:
        gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between fetch and load/store requesters.
// Ports: Clk, reset (async, active-low), bus (slave view of the bundle).
// Optional macro RAM_TIMEOUT_EN adds a BUSY timeout and ABORT state.
import ram_port_arbiter_pkg::*;

module ram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               Clk,
  input  logic               reset,
  ram_port_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state;
  state_t            state_nx;
  logic [1:0]        gnt;
  logic              grant;
  logic              last_data;
  logic              own_data;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] rdata_q;
  logic              finish;

  rr_arbiter2 u_rr (
    .req_fetch (bus.fetchReq),
    .req_data  (bus.dataReq),
    .last_data (last_data),
    .gnt       (gnt)
  );

  // A still-high MFC means the RAM has not released the last access.
  assign grant = (state == S_IDLE) && !bus.ramMFC && (|gnt);

`ifdef RAM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          expire;

  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (grant) begin
      cnt <= '0;
    end else if (state == S_BUSY) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (grant) state_nx = S_BUSY;
      end
      S_BUSY: begin
        // Completion wins over a coincident timeout.
        if (bus.ramMFC) begin
          state_nx = S_DONE;
        end
`ifdef RAM_TIMEOUT_EN
        else if (expire) begin
          state_nx = S_ABORT;
        end
`endif
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
`ifdef RAM_TIMEOUT_EN
      S_ABORT: begin
        state_nx = S_IDLE;
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      last_data <= 1'b1;
      own_data  <= 1'b0;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
    end else begin
      if (grant) begin
        last_data <= gnt[1];
        own_data  <= gnt[1];
        if (gnt[1]) begin
          rw_q    <= bus.dataRW;
          addr_q  <= bus.dataAddr;
          wdata_q <= bus.dataWData;
          size_q  <= bus.dataSize;
        end else begin
          rw_q    <= FETCH_RW;
          addr_q  <= bus.fetchAddr;
          wdata_q <= FETCH_WDATA;
          size_q  <= FETCH_SIZE;
        end
      end
      if (state == S_BUSY && bus.ramMFC && rw_q) begin
        rdata_q <= bus.ramDataOut;
      end
    end
  end

`ifdef RAM_TIMEOUT_EN
  assign finish  = (state == S_DONE) || (state == S_ABORT);
  assign bus.err = (state == S_ABORT);
`else
  assign finish  = (state == S_DONE);
  assign bus.err = 1'b0;
`endif

  assign bus.fetchDone   = finish && !own_data;
  assign bus.dataDone    = finish && own_data;
  assign bus.rdata       = rdata_q;
  assign bus.ramMFA      = (state == S_BUSY);
  assign bus.ramRW       = rw_q;
  assign bus.ramAddress  = addr_q;
  assign bus.ramDataIn   = wdata_q;
  assign bus.ramDataSize = size_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized checks of ram_port_arbiter against a
// behavioural arbitration model and a simple RAM responder.
module tb_ram_port_arbiter;

  localparam int TO = 15;

  logic Clk;
  logic reset;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          total;
  int          bad;
  int          dbl;
  int          mfc_delay;
  int          mfa_cnt;
  bit          ram_mute;
  bit          mfc_hold;
  logic [31:0] ram_val;

  bit          m_last_data;
  logic [31:0] m_rdata;

  // RAM responder: MFC rises mfc_delay cycles after MFA, drops once
  // MFA has gone low (unless held).
  always @(posedge Clk) begin
    if (!reset) begin
      bus.ramMFC     <= 1'b0;
      bus.ramDataOut <= '0;
      mfa_cnt = 0;
    end else if (bus.ramMFA === 1'b1) begin
      mfa_cnt++;
      if (!ram_mute && mfa_cnt >= mfc_delay) begin
        bus.ramMFC     <= 1'b1;
        bus.ramDataOut <= ram_val;
      end
    end else begin
      mfa_cnt = 0;
      if (!mfc_hold) bus.ramMFC <= 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (bus.fetchDone === 1'b1 && bus.dataDone === 1'b1) dbl++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Round-robin rule: lone request wins; a tie goes to the side
  // that did not win last. Returns 1 when data wins.
  function automatic bit pick(input bit f, input bit d);
    if (f && d) return !m_last_data;
    return d;
  endfunction

  task automatic model_reset();
    m_last_data = 1'b1;
    m_rdata     = '0;
  endtask

  task automatic serve(input bit is_data, input int dly,
                       input logic [31:0] rv, input int gwait);
    logic [8:0]  a;
    logic        rw;
    logic [1:0]  sz;
    logic [31:0] wd;
    int          n;
    bit          stable;
    a  = is_data ? bus.dataAddr : bus.fetchAddr;
    rw = is_data ? bus.dataRW : 1'b1;
    sz = is_data ? bus.dataSize : 2'b11;
    wd = is_data ? bus.dataWData : 32'h0;
    mfc_delay = dly;
    ram_val   = rv;
    n = 0;
    while (bus.ramMFA !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    chk("grant_mfa", 32'(bus.ramMFA), 32'(1));
    if (gwait >= 0) chk("grant_wait", 32'(n), 32'(gwait));
    chk("ram_addr", 32'(bus.ramAddress), 32'(a));
    chk("ram_rw", 32'(bus.ramRW), 32'(rw));
    chk("ram_size", 32'(bus.ramDataSize), 32'(sz));
    chk("ram_wdata", bus.ramDataIn, wd);
    n = 0;
    stable = 1'b1;
    while (bus.fetchDone !== 1'b1 && bus.dataDone !== 1'b1
           && n < 60) begin
      if (bus.ramMFA === 1'b1 &&
          (bus.ramAddress !== a || bus.ramRW !== rw ||
           bus.ramDataSize !== sz || bus.ramDataIn !== wd))
        stable = 1'b0;
      step(1);
      n++;
    end
    if (rw) m_rdata = rv;
    m_last_data = is_data;
    chk("busy_stable", 32'(stable), 32'(1));
    chk("latency", 32'(n), 32'(dly + 1));
    chk("fetch_done", 32'(bus.fetchDone), 32'(!is_data));
    chk("data_done", 32'(bus.dataDone), 32'(is_data));
    chk("done_err", 32'(bus.err), 32'(0));
    chk("done_mfa", 32'(bus.ramMFA), 32'(0));
    chk("rdata", bus.rdata, m_rdata);
    if (is_data) bus.dataReq = 1'b0;
    else bus.fetchReq = 1'b0;
    step(1);
    chk("pulse_end",
        32'(bus.fetchDone | bus.dataDone), 32'(0));
  endtask

  task automatic set_data(input logic [8:0] a, input logic rw,
                          input logic [1:0] sz,
                          input logic [31:0] wd);
    bus.dataAddr  = a;
    bus.dataRW    = rw;
    bus.dataSize  = sz;
    bus.dataWData = wd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.fetchReq = 1'b0;
    bus.dataReq  = 1'b0;
    model_reset();
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    int          n;
    bit          f;
    bit          d;
    bit          w;
    total = 0;
    bad = 0;
    dbl = 0;
    mfc_delay = 1;
    ram_mute = 1'b0;
    mfc_hold = 1'b0;
    ram_val = '0;
    reset = 1'b0;
    bus.fetchReq  = 1'b0;
    bus.fetchAddr = '0;
    bus.dataReq   = 1'b0;
    set_data('0, 1'b1, 2'b00, '0);
    model_reset();
    step(2);

    chk("rst_mfa", 32'(bus.ramMFA), 32'(0));
    chk("rst_fdone", 32'(bus.fetchDone), 32'(0));
    chk("rst_ddone", 32'(bus.dataDone), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_addr", 32'(bus.ramAddress), 32'(0));
    chk("rst_wdata", bus.ramDataIn, 32'h0);
    chk("rst_size", 32'(bus.ramDataSize), 32'(0));
    chk("rst_rw", 32'(bus.ramRW), 32'(1));
    reset = 1'b1;
    step(1);

    // Single fetch, RAM answers two cycles after MFA.
    bus.fetchAddr = 9'h010;
    bus.fetchReq  = 1'b1;
    serve(1'b0, 2, 32'hDEADBEEF, 1);

    // Three back-to-back ties from reset.
    do_reset();
    bus.fetchAddr = 9'h020;
    set_data(9'h040, 1'b1, 2'b01, 32'h0);
    bus.fetchReq = 1'b1;
    bus.dataReq  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = pick(1'b1, 1'b1);
      serve(w, 1, 32'hA000_0000 + 32'(i), i == 0 ? -1 : 1);
      if (w) bus.dataReq = 1'b1;
      else bus.fetchReq = 1'b1;
    end
    bus.fetchReq = 1'b0;
    bus.dataReq  = 1'b0;
    step(1);

    // Word write leaves rdata alone.
    set_data(9'h100, 1'b0, 2'b11, 32'h12345678);
    bus.dataReq = 1'b1;
    serve(1'b1, 3, 32'hBAD0_BAD0, 1);

    // MFC held after DONE blocks the next grant.
    mfc_hold = 1'b1;
    bus.fetchAddr = 9'h0F0;
    bus.fetchReq  = 1'b1;
    serve(1'b0, 1, 32'h5555_AAAA, 1);
    set_data(9'h1FC, 1'b1, 2'b00, 32'h0);
    bus.dataReq = 1'b1;
    step(4);
    chk("hold_mfa", 32'(bus.ramMFA), 32'(0));
    chk("hold_ddone", 32'(bus.dataDone), 32'(0));
    mfc_hold = 1'b0;
    serve(1'b1, 2, 32'h0BAD_F00D, -1);

    // Reset during BUSY drops the access.
    ram_mute = 1'b1;
    set_data(9'h0AA, 1'b1, 2'b11, 32'h0);
    bus.dataReq = 1'b1;
    n = 0;
    while (bus.ramMFA !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("pre_rst_busy", 32'(bus.ramMFA), 32'(1));
    bus.fetchAddr = 9'h044;
    bus.fetchReq  = 1'b1;
    step(2);
    reset = 1'b0;
    #1;
    chk("midrst_mfa", 32'(bus.ramMFA), 32'(0));
    chk("midrst_done",
        32'(bus.fetchDone | bus.dataDone), 32'(0));
    chk("midrst_rdata", bus.rdata, 32'h0);
    model_reset();
    step(2);
    ram_mute = 1'b0;
    reset = 1'b1;
    w = pick(1'b1, 1'b1);
    serve(w, 1, 32'h1111_2222, -1);
    serve(!w, 2, 32'h3333_4444, 1);

    // RAM never answers.
    ram_mute = 1'b1;
    bus.fetchAddr = 9'h0C0;
    bus.fetchReq  = 1'b1;
    n = 0;
    while (bus.ramMFA !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("to_grant", 32'(bus.ramMFA), 32'(1));
`ifdef RAM_TIMEOUT_EN
    n = 0;
    while (bus.fetchDone !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_err", 32'(bus.err), 32'(1));
    chk("to_ddone", 32'(bus.dataDone), 32'(0));
    chk("to_rdata", bus.rdata, m_rdata);
    m_last_data = 1'b0;
    bus.fetchReq = 1'b0;
    step(1);
    chk("to_err_end", 32'(bus.err), 32'(0));
    ram_mute = 1'b0;
    set_data(9'h0C4, 1'b1, 2'b11, 32'h0);
    bus.dataReq = 1'b1;
    serve(1'b1, 1, 32'hCAFE_0001, 1);
`else
    n = 0;
    while (bus.fetchDone !== 1'b1 && n < 3 * TO) begin
      step(1);
      n++;
    end
    chk("stuck_cycles", 32'(n), 32'(3 * TO));
    chk("stuck_mfa", 32'(bus.ramMFA), 32'(1));
    chk("stuck_err", 32'(bus.err), 32'(0));
    ram_mute = 1'b0;
    do_reset();
`endif

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      f = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!f && !d) f = 1'b1;
      bus.fetchAddr = 9'($urandom);
      set_data(9'($urandom), 1'($urandom_range(0, 1)),
               2'($urandom), $urandom);
      bus.fetchReq = f;
      bus.dataReq  = d;
      w = pick(f, d);
      serve(w, $urandom_range(1, 4), $urandom, 1);
      if (f && d) serve(!w, $urandom_range(1, 4), $urandom, 1);
    end

    chk("no_double_done", 32'(dbl), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
